// File: rtl/lag_pl_buffers.sv
// lag_pl_buffers: bank of n independent first-word-fall-through flit FIFOs,
// one per physical link, each size entries deep (size >= 2, any value).
//
// Ports:
//   clk       - sole clock, rising edge
//   rst_n     - asynchronous active-low reset; clears pointers, counts, storage
//   push[n]   - per-channel write enable (dropped when full unless popping)
//   pop[n]    - per-channel dequeue enable (ignored when empty)
//   data_in   - per-channel write flit
//   data_out  - per-channel head flit, read straight from storage
//   flags     - per-channel full/empty/nearly_full/nearly_empty from count
//
// Optional build macro: LAG_PL_BUFFERS_CHECK_EN compiles in simulation
// checkers that report pushes to a full FIFO and pops of an empty FIFO.

package lag_pl_buffers_pkg;

   localparam int unsigned FLIT_DATA_W = 32;
   localparam int unsigned FLIT_VC_W   = 2;

   typedef struct packed {
      logic                 tail;
      logic                 head;
      logic [FLIT_VC_W-1:0] vc;
   } flit_ctrl_t;

   typedef struct packed {
      flit_ctrl_t             control;
      logic [FLIT_DATA_W-1:0] data;
   } flit_t;

   typedef struct packed {
      logic full;
      logic empty;
      logic nearly_full;
      logic nearly_empty;
   } fifov_flags_t;

endpackage

module lag_pl_buffers
   import lag_pl_buffers_pkg::*;
#(
   parameter int unsigned size = 8,
   parameter int unsigned n    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [n-1:0]           push,
   input  logic [n-1:0]           pop,
   input  flit_t [n-1:0]          data_in,
   output flit_t [n-1:0]          data_out,
   output fifov_flags_t [n-1:0]   flags
);

   localparam int unsigned PW = (size > 1) ? $clog2(size) : 1;
   localparam int unsigned CW = $clog2(size + 1);

   for (genvar i = 0; i < int'(n); i++) begin : g_ch

      flit_t          mem [size];
      logic [PW-1:0]  rd_ptr;
      logic [PW-1:0]  wr_ptr;
      logic [CW-1:0]  count;
      logic           is_full;
      logic           is_empty;
      logic           push_ok;
      logic           pop_ok;
      fifov_flags_t   flags_c;

      assign is_empty = (count == '0);
      assign is_full  = (count == CW'(size));

      // A full FIFO can take a push only while the head is leaving.
      assign pop_ok  = pop[i] && !is_empty;
      assign push_ok = push[i] && (!is_full || pop[i]);

      // Storage; cleared on reset so data_out reads zero afterwards.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int unsigned k = 0; k < size; k++) begin
               mem[k] <= '0;
            end
         end else if (push_ok) begin
            mem[wr_ptr] <= data_in[i];
         end
      end

      // Pointers wrap at size-1; size need not be a power of two.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok) begin
               wr_ptr <= (wr_ptr == PW'(size - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_ok) begin
               rd_ptr <= (rd_ptr == PW'(size - 1)) ? '0 : rd_ptr + PW'(1);
            end
         end
      end

      // Occupancy count.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            count <= '0;
         end else begin
            case ({push_ok, pop_ok})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end

      // Flags decode only the registered count: no path from push/pop.
      always_comb begin
         flags_c              = '0;
         flags_c.empty        = is_empty;
         flags_c.full         = is_full;
         flags_c.nearly_empty = (count <= CW'(1));
         flags_c.nearly_full  = (count >= CW'(size - 1));
      end

      assign flags[i]    = flags_c;
      assign data_out[i] = mem[rd_ptr];

`ifdef LAG_PL_BUFFERS_CHECK_EN
      // Report illegal requests; behaviour is still drop / no-op.
      always_ff @(posedge clk) begin
         if (rst_n) begin
            if (push[i] && is_full && !pop[i]) begin
               $error("lag_pl_buffers: push to full FIFO on channel %0d", i);
            end
            if (pop[i] && is_empty) begin
               $error("lag_pl_buffers: pop of empty FIFO on channel %0d", i);
            end
         end
      end
`endif

   end

endmodule

// File: tb/tb_lag_pl_buffers.sv
// Self-checking bench for lag_pl_buffers (size=8, n=4) using a per-channel
// queue scoreboard: flits are queued when an accepted push is driven and
// compared against data_out when the bench pops them.
module tb_lag_pl_buffers;
   import lag_pl_buffers_pkg::*;

   localparam int unsigned SIZE = 8;
   localparam int unsigned N    = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N-1:0]         push;
   logic [N-1:0]         pop;
   flit_t [N-1:0]        data_in;
   flit_t [N-1:0]        data_out;
   fifov_flags_t [N-1:0] flags;

   flit_t q [N][$];
   int    total = 0;
   int    bad   = 0;

   lag_pl_buffers #(.size(SIZE), .n(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .data_in  (data_in),
      .data_out (data_out),
      .flags    (flags)
   );

   always #5 clk = ~clk;

   function automatic flit_t mk(input int v, input bit tail);
      flit_t f;
      f              = '0;
      f.control.tail = tail;
      f.control.head = (v % 5 == 0);
      f.control.vc   = 2'(v);
      f.data         = {16'(v), 16'($urandom)};
      return f;
   endfunction

   function automatic fifov_flags_t exp_flags(input int cnt);
      fifov_flags_t f;
      f              = '0;
      f.empty        = (cnt == 0);
      f.full         = (cnt == int'(SIZE));
      f.nearly_empty = (cnt <= 1);
      f.nearly_full  = (cnt >= int'(SIZE) - 1);
      return f;
   endfunction

   // Advance one clock: update the scoreboard with accepted requests, then
   // return 1 time unit after the edge with requests deasserted.
   task automatic tick();
      for (int c = 0; c < int'(N); c++) begin
         int cnt;
         bit pa;
         bit wa;
         cnt = q[c].size();
         pa  = pop[c] && (cnt > 0);
         wa  = push[c] && ((cnt < int'(SIZE)) || pop[c]);
         if (pa) void'(q[c].pop_front());
         if (wa) q[c].push_back(data_in[c]);
      end
      @(posedge clk);
      #1;
      push = '0;
      pop  = '0;
   endtask

   task automatic test_reset();
      flit_t a;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 0; c < int'(N); c++) begin
         total++;
         if (flags[c] !== exp_flags(0)) begin
            bad++;
            $display("FAIL reset_flags ch%0d: got %b want %b", c, flags[c], exp_flags(0));
         end
         total++;
         if (data_out[c] !== '0) begin
            bad++;
            $display("FAIL reset_data ch%0d: got %h want 0", c, data_out[c]);
         end
      end
      // First push on channel 0.
      a = mk(100, 1'b0);
      data_in[0] = a;
      push[0] = 1'b1;
      tick();
      total++;
      if (data_out[0] !== a) begin
         bad++;
         $display("FAIL first_push_data: got %h want %h", data_out[0], a);
      end
      total++;
      if (flags[0] !== exp_flags(1)) begin
         bad++;
         $display("FAIL first_push_flags: got %b want %b", flags[0], exp_flags(1));
      end
      for (int c = 1; c < int'(N); c++) begin
         total++;
         if (flags[c] !== exp_flags(0) || data_out[c] !== '0) begin
            bad++;
            $display("FAIL first_push_other ch%0d: got %b/%h want %b/0", c, flags[c], data_out[c], exp_flags(0));
         end
      end
      pop[0] = 1'b1;
      tick();
   endtask

   task automatic test_fill_drain();
      flit_t exp;
      for (int i = 0; i < int'(SIZE) + 1; i++) begin
         data_in[2] = mk(200 + i, i == int'(SIZE) - 1);
         push[2] = 1'b1;
         tick();
         total++;
         if (flags[2] !== exp_flags(q[2].size())) begin
            bad++;
            $display("FAIL fill_flags push%0d: got %b want %b", i, flags[2], exp_flags(q[2].size()));
         end
      end
      for (int i = 0; i < int'(SIZE); i++) begin
         exp = q[2][0];
         total++;
         if (data_out[2] !== exp) begin
            bad++;
            $display("FAIL drain_data D%0d: got %h want %h", i, data_out[2], exp);
         end
         pop[2] = 1'b1;
         tick();
         total++;
         if (flags[2] !== exp_flags(q[2].size())) begin
            bad++;
            $display("FAIL drain_flags pop%0d: got %b want %b", i, flags[2], exp_flags(q[2].size()));
         end
      end
      total++;
      if (flags[2].empty !== 1'b1) begin
         bad++;
         $display("FAIL drain_empty: got %b want 1", flags[2].empty);
      end
   endtask

   task automatic test_simultaneous();
      flit_t exp;
      for (int i = 0; i < 3; i++) begin
         data_in[0] = mk(300 + i, 1'b0);
         push[0] = 1'b1;
         tick();
      end
      // count 3: push+pop keeps count, head advances.
      exp = q[0][0];
      total++;
      if (data_out[0] !== exp) begin
         bad++;
         $display("FAIL simul3_head_before: got %h want %h", data_out[0], exp);
      end
      data_in[0] = mk(310, 1'b0);
      push[0] = 1'b1;
      pop[0]  = 1'b1;
      tick();
      total++;
      if (data_out[0] !== q[0][0] || q[0].size() != 3) begin
         bad++;
         $display("FAIL simul3_head_after: got %h want %h", data_out[0], q[0][0]);
      end
      total++;
      if (flags[0] !== exp_flags(3)) begin
         bad++;
         $display("FAIL simul3_flags: got %b want %b", flags[0], exp_flags(3));
      end
      // Fill to full, then push+pop at full.
      while (q[0].size() < int'(SIZE)) begin
         data_in[0] = mk(320 + q[0].size(), 1'b0);
         push[0] = 1'b1;
         tick();
      end
      data_in[0] = mk(399, 1'b0);
      push[0] = 1'b1;
      pop[0]  = 1'b1;
      tick();
      total++;
      if (flags[0] !== exp_flags(int'(SIZE)) || q[0].size() != int'(SIZE)) begin
         bad++;
         $display("FAIL simul_full_flags: got %b want %b", flags[0], exp_flags(int'(SIZE)));
      end
      while (q[0].size() > 0) begin
         exp = q[0][0];
         total++;
         if (data_out[0] !== exp) begin
            bad++;
            $display("FAIL simul_full_drain: got %h want %h", data_out[0], exp);
         end
         pop[0] = 1'b1;
         tick();
      end
      // Empty: push+pop -> count 1, no bypass.
      data_in[0] = mk(400, 1'b0);
      push[0] = 1'b1;
      pop[0]  = 1'b1;
      tick();
      total++;
      if (flags[0] !== exp_flags(1) || q[0].size() != 1) begin
         bad++;
         $display("FAIL simul_empty_flags: got %b want %b", flags[0], exp_flags(1));
      end
      total++;
      if (data_out[0] !== q[0][0]) begin
         bad++;
         $display("FAIL simul_empty_data: got %h want %h", data_out[0], q[0][0]);
      end
      pop[0] = 1'b1;
      tick();
   endtask

   task automatic test_wrap();
      flit_t exp;
      int    popped = 0;
      for (int i = 0; i < 20; i++) begin
         data_in[1] = mk(500 + i, 1'b0);
         push[1] = 1'b1;
         if (q[1].size() >= 2) begin
            exp = q[1][0];
            total++;
            if (data_out[1] !== exp) begin
               bad++;
               $display("FAIL wrap_data pop%0d: got %h want %h", popped, data_out[1], exp);
            end
            pop[1] = 1'b1;
            popped++;
         end
         tick();
         total++;
         if (flags[1] !== exp_flags(q[1].size())) begin
            bad++;
            $display("FAIL wrap_flags step%0d: got %b want %b", i, flags[1], exp_flags(q[1].size()));
         end
      end
      while (q[1].size() > 0) begin
         exp = q[1][0];
         total++;
         if (data_out[1] !== exp) begin
            bad++;
            $display("FAIL wrap_drain: got %h want %h", data_out[1], exp);
         end
         pop[1] = 1'b1;
         tick();
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         data_in[3] = mk(600 + i, 1'b0);
         push[3] = 1'b1;
         tick();
      end
      total++;
      if (flags[3] !== exp_flags(5)) begin
         bad++;
         $display("FAIL mid_pre_flags: got %b want %b", flags[3], exp_flags(5));
      end
      #2;
      rst_n = 1'b0;
      #1;
      for (int c = 0; c < int'(N); c++) q[c].delete();
      total++;
      if (flags[3] !== exp_flags(0)) begin
         bad++;
         $display("FAIL mid_reset_flags: got %b want %b", flags[3], exp_flags(0));
      end
      total++;
      if (data_out[3] !== '0) begin
         bad++;
         $display("FAIL mid_reset_data: got %h want 0", data_out[3]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_tail_pop();
      flit_t t;
      flit_t b;
      t = mk(700, 1'b1);
      b = mk(701, 1'b0);
      data_in[0] = t;
      push[0] = 1'b1;
      tick();
      data_in[0] = b;
      push[0] = 1'b1;
      tick();
      pop[0] = 1'b1;
      #1;
      total++;
      if (data_out[0].control.tail !== 1'b1 || data_out[0] !== q[0][0]) begin
         bad++;
         $display("FAIL tail_same_cycle: got %h want %h", data_out[0], q[0][0]);
      end
      tick();
      total++;
      if (data_out[0] !== b) begin
         bad++;
         $display("FAIL tail_next: got %h want %h", data_out[0], b);
      end
      pop[0] = 1'b1;
      tick();
      total++;
      if (flags[0] !== exp_flags(0)) begin
         bad++;
         $display("FAIL tail_final_flags: got %b want %b", flags[0], exp_flags(0));
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      push    = '0;
      pop     = '0;
      data_in = '0;
      test_reset();
      test_fill_drain();
      test_simultaneous();
      test_wrap();
      test_reset_mid();
      test_tail_pop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
